mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Sequences all accesses to the single-port 256x16 data RAM. Two requesters share it:
//   the RISC processor (read/write) and the memory-dump stepper (read-only).
//   Replaces the static dump/CPU address mux with a req/gnt/rvalid handshake, so a dump
//   read can never corrupt an in-flight CPU write.
//   Sits between the processor, the dump counter, the RAM and the display path.
// PARAMETERS
//   ADDR_W  16  requester/RAM address width; RAM decodes [7:0], upper bits pass through
//   DATA_W  16  data width
//   RD_LAT   1  RAM read latency in clk cycles after the address edge; legal 1..4
// PORTS
//   clk         in   1       system clock (clk_100 domain)
//   rst         in   1       asynchronous, active-low reset
//   cpu_req     in   1       CPU access request; hold until cpu_gnt
//   cpu_we      in   1       1 = write, 0 = read; valid with cpu_req
//   cpu_addr    in   ADDR_W  CPU address; stable while cpu_req=1
//   cpu_wdata   in   DATA_W  CPU write data; stable while cpu_req=1
//   cpu_gnt     out  1       one-cycle pulse: CPU request accepted
//   cpu_rvalid  out  1       one-cycle pulse: cpu_rdata valid
//   cpu_rdata   out  DATA_W  CPU read data; held until the next CPU read completes
//   dbg_req     in   1       dump-port read request; hold until dbg_gnt
//   dbg_addr    in   ADDR_W  dump address; stable while dbg_req=1
//   dbg_gnt     out  1       one-cycle pulse: dump request accepted
//   dbg_rvalid  out  1       one-cycle pulse: dbg_rdata valid
//   dbg_rdata   out  DATA_W  dump read data; held until the next dump read completes
//   dump_mode   in   1       1 = dump port has fixed priority; 0 = round-robin
//   mem_addr    out  ADDR_W  registered RAM address
//   mem_wdata   out  DATA_W  registered RAM write data
//   mem_we      out  1       registered RAM write enable
//   mem_rdata   in   DATA_W  RAM read data
//   busy        out  1       1 whenever state != IDLE
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, all outputs 0, last_win=DBG (CPU wins the first tie).
//     Any in-flight access is dropped. mem_we falls immediately. No rvalid is issued.
//   FSM states: IDLE, ACCESS, RDWAIT, RESP.
//   IDLE: at each edge, sample requests. If there is a winner: latch its addr/wdata/we into
//     mem_*, pulse its gnt for the following cycle, go to ACCESS. With no request, stay IDLE.
//   Winner selection:
//     - dump_mode=1: dbg wins whenever dbg_req=1.
//     - dump_mode=0 and both requesting: the requester not equal to last_win wins.
//     - A single requester always wins. last_win updates on every grant.
//   ACCESS (1 cycle): RAM samples mem_*.
//     - Write: mem_we=1 for exactly this cycle, then IDLE.
//     - Read: go to RDWAIT with cnt=RD_LAT-1, or straight to RESP when RD_LAT=1.
//   RDWAIT: count cnt down to 0, then go to RESP.
//   RESP: capture mem_rdata into the winner's rdata, pulse its rvalid the next cycle, go IDLE.
//   Dump-port accesses are always reads; mem_we=0 for them.
//   mem_we is 0 in every state except ACCESS-write.
//   Latency with RD_LAT=1, counting from the sampling edge E0:
//     - gnt and mem_* valid after E0.
//     - Read: rvalid high in the cycle after E2.
//     - Write: complete at E1.
//   Throughput: one access per 2 cycles (write) or 3+RD_LAT-1 cycles (read).
//     Exactly one IDLE cycle between accesses.
//   A requester that keeps req=1 after its gnt is treated as a new request at the next IDLE.
//   mem_addr/mem_wdata hold their last value in IDLE. No address arithmetic or wrap is done.
//   Requests arriving while busy=1 wait. They are never lost while req is held.
// TESTING
//   1 Reset, single CPU write: addr=0x0005, data=0xBEEF -> cpu_gnt 1 cycle after sample,
//     mem_we=1 for 1 cycle, busy back to 0 at E1.
//   2 CPU read of 0x0005 after test 1, RD_LAT=1 -> cpu_rvalid 1 cycle after E2,
//     cpu_rdata=0xBEEF, dbg_* outputs stay 0.
//   3 Both requesters held high, dump_mode=0 -> grant order CPU, DBG, CPU, DBG;
//     no requester is granted twice in a row.
//   4 Both requesters held high, dump_mode=1 -> DBG granted on every IDLE, CPU never
//     granted until dbg_req drops.
//   5 Assert rst=0 mid-read in RDWAIT with RD_LAT=3 -> all outputs 0 at once,
//     no rvalid after release, next request serviced normally.
//   6 Dump read of 0x0105 after test 1 -> mem_addr=0x0105, dbg_rdata=0xBEEF (RAM decodes [7:0]).

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port data RAM arbiter for CPU and dump requesters
// Grants one access at a time via req/gnt/rvalid; dump-port reads can never overlap a CPU write.
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dump_mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, RESP} state_t;

  state_t     state;
  logic       last_win;   // 1 = dump port won the previous grant
  logic       owner;      // 1 = current access belongs to the dump port
  logic [1:0] cnt;
  logic       any_req;
  logic       pick_dbg;

  always_comb begin
    any_req  = cpu_req | dbg_req;
    pick_dbg = dbg_req;
    if (!dump_mode && cpu_req && dbg_req)
      pick_dbg = ~last_win;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_win   <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
      cpu_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dbg_gnt    <= 1'b0;
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cpu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner    <= pick_dbg;
            last_win <= pick_dbg;
            state    <= ACCESS;
            busy     <= 1'b1;
            if (pick_dbg) begin
              mem_addr <= dbg_addr;
              mem_we   <= 1'b0;
              dbg_gnt  <= 1'b1;
            end else begin
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              mem_we    <= cpu_we;
              cpu_gnt   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          mem_we <= 1'b0;
          if (mem_we) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (RD_LAT == 1) begin
            state <= RESP;
          end else begin
            state <= RDWAIT;
            cnt   <= 2'(RD_LAT - 1);
          end
        end
        RDWAIT: begin
          // Leaves after RD_LAT-1 cycles so RESP samples the first valid RAM word.
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1)
            state <= RESP;
        end
        RESP: begin
          if (owner) begin
            dbg_rdata  <= mem_rdata;
            dbg_rvalid <= 1'b1;
          end else begin
            cpu_rdata  <= mem_rdata;
            cpu_rvalid <= 1'b1;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // instance A: RD_LAT=1
  logic        rst, cpu_req, cpu_we, dbg_req, dump_mode;
  logic [15:0] cpu_addr, cpu_wdata, dbg_addr;
  logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_we, busy;
  logic [15:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;

  // instance B: RD_LAT=3
  logic        b_rst, b_cpu_req, b_cpu_we, b_dbg_req, b_dump_mode;
  logic [15:0] b_cpu_addr, b_cpu_wdata, b_dbg_addr;
  logic        b_cpu_gnt, b_cpu_rvalid, b_dbg_gnt, b_dbg_rvalid, b_mem_we, b_busy;
  logic [15:0] b_cpu_rdata, b_dbg_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dump_mode(dump_mode),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(b_rst),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_gnt(b_cpu_gnt), .cpu_rvalid(b_cpu_rvalid), .cpu_rdata(b_cpu_rdata),
    .dbg_req(b_dbg_req), .dbg_addr(b_dbg_addr), .dbg_gnt(b_dbg_gnt),
    .dbg_rvalid(b_dbg_rvalid), .dbg_rdata(b_dbg_rdata), .dump_mode(b_dump_mode),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // RAM models decode only the low address byte
  logic [15:0] ram_a [256];
  logic [15:0] rd_a;
  always @(posedge clk) begin
    if (mem_we) ram_a[mem_addr[7:0]] <= mem_wdata;
    rd_a <= ram_a[mem_addr[7:0]];
  end
  assign mem_rdata = rd_a;

  logic [15:0] ram_b [256];
  logic [15:0] pipe_b [3];
  always @(posedge clk) begin
    if (b_mem_we) ram_b[b_mem_addr[7:0]] <= b_mem_wdata;
    pipe_b[0] <= ram_b[b_mem_addr[7:0]];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign b_mem_rdata = pipe_b[2];

  logic [15:0] cpu_q[$];
  logic [15:0] dbg_q[$];
  logic [15:0] b_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && cpu_rvalid === 1'b1) begin
      if (cpu_q.size() == 0) check("cpu_rvalid_unexpected", 32'd1, 32'd0);
      else check("cpu_rdata_sb", {16'h0, cpu_rdata}, {16'h0, cpu_q.pop_front()});
    end
    if (rst === 1'b1 && dbg_rvalid === 1'b1) begin
      if (dbg_q.size() == 0) check("dbg_rvalid_unexpected", 32'd1, 32'd0);
      else check("dbg_rdata_sb", {16'h0, dbg_rdata}, {16'h0, dbg_q.pop_front()});
    end
    if (b_rst === 1'b1 && b_cpu_rvalid === 1'b1) begin
      if (b_q.size() == 0) check("b_rvalid_unexpected", 32'd1, 32'd0);
      else check("b_rdata_sb", {16'h0, b_cpu_rdata}, {16'h0, b_q.pop_front()});
    end
  end

  task automatic wait_gnt_a(output logic who_dbg);
    bit ok = 0;
    who_dbg = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_gnt || dbg_gnt) begin
        ok = 1;
        who_dbg = dbg_gnt;
        break;
      end
    end
    check("gnt_timeout_a", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_idle_a();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    check("idle_timeout_a", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_gnt_b();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_cpu_gnt) begin ok = 1; break; end
    end
    check("gnt_timeout_b", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_idle_b();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!b_busy) begin ok = 1; break; end
    end
    check("idle_timeout_b", {31'd0, ok}, 32'd1);
  endtask

  task automatic cpu_op_a(input logic we, input logic [15:0] addr, input logic [15:0] wd);
    logic who;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    wait_gnt_a(who);
    cpu_req = 1'b0; cpu_we = 1'b0;
    check("cpu_op_owner", {31'd0, who}, 32'd0);
    wait_idle_a();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic who;
    logic exp3 [4];
    int   n_rv;
    int   lat;
    bit   got;
    exp3 = '{1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_addr = '0; dump_mode = 1'b0;
    b_rst = 1'b0; b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = '0; b_cpu_wdata = '0;
    b_dbg_req = 1'b0; b_dbg_addr = '0; b_dump_mode = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    check("rst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
    rst = 1'b1; b_rst = 1'b1;
    @(negedge clk);

    // single CPU write with exact cycle timing
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0005; cpu_wdata = 16'hBEEF;
    @(negedge clk);
    check("t1_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    check("t1_mem_we", {31'd0, mem_we}, 32'd1);
    check("t1_mem_addr", {16'd0, mem_addr}, 32'h0005);
    check("t1_mem_wdata", {16'd0, mem_wdata}, 32'hBEEF);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    check("t1_gnt_pulse", {31'd0, cpu_gnt}, 32'd0);
    check("t1_mem_we_drop", {31'd0, mem_we}, 32'd0);
    check("t1_busy_drop", {31'd0, busy}, 32'd0);

    cpu_op_a(1'b1, 16'h0042, 16'h5A5A);

    // CPU read with RD_LAT=1 timing
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
    cpu_q.push_back(16'hBEEF);
    @(negedge clk);
    check("t2_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    check("t2_mem_we", {31'd0, mem_we}, 32'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    check("t2_rvalid_early", {31'd0, cpu_rvalid}, 32'd0);
    check("t2_busy_mid", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("t2_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    check("t2_busy_end", {31'd0, busy}, 32'd0);
    check("t2_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    check("t2_dbg_rdata", {16'd0, dbg_rdata}, 32'd0);

    // dump read with upper address bits set
    dbg_req = 1'b1; dbg_addr = 16'h0105;
    dbg_q.push_back(16'hBEEF);
    @(negedge clk);
    check("t6_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
    check("t6_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    check("t6_mem_addr", {16'd0, mem_addr}, 32'h0105);
    check("t6_mem_we", {31'd0, mem_we}, 32'd0);
    dbg_req = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd1);
    check("t6_cpu_rdata_held", {16'd0, cpu_rdata}, 32'hBEEF);

    // round-robin with both requesters held
    dump_mode = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0042;
    dbg_req = 1'b1; dbg_addr = 16'h0105;
    for (int g = 0; g < 4; g++) begin
      wait_gnt_a(who);
      check("t3_order", {31'd0, who}, {31'd0, exp3[g]});
      if (who) dbg_q.push_back(16'hBEEF);
      else     cpu_q.push_back(16'h5A5A);
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    wait_idle_a();

    // fixed dump priority
    dump_mode = 1'b1;
    cpu_req = 1'b1; dbg_req = 1'b1;
    for (int g = 0; g < 3; g++) begin
      wait_gnt_a(who);
      check("t4_dbg_prio", {31'd0, who}, 32'd1);
      if (who) dbg_q.push_back(16'hBEEF);
      else     cpu_q.push_back(16'h5A5A);
    end
    dbg_req = 1'b0;
    wait_gnt_a(who);
    check("t4_cpu_after", {31'd0, who}, 32'd0);
    if (who) dbg_q.push_back(16'hBEEF);
    else     cpu_q.push_back(16'h5A5A);
    cpu_req = 1'b0;
    wait_idle_a();
    dump_mode = 1'b0;

    // reset in RDWAIT on the RD_LAT=3 instance
    b_cpu_req = 1'b1; b_cpu_we = 1'b1; b_cpu_addr = 16'h0007; b_cpu_wdata = 16'h1357;
    wait_gnt_b();
    b_cpu_req = 1'b0; b_cpu_we = 1'b0;
    wait_idle_b();
    b_cpu_req = 1'b1; b_cpu_addr = 16'h0007;
    wait_gnt_b();
    b_cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_busy_rdwait", {31'd0, b_busy}, 32'd1);
    b_rst = 1'b0;
    #1;
    check("t5_rst_busy", {31'd0, b_busy}, 32'd0);
    check("t5_rst_mem_addr", {16'd0, b_mem_addr}, 32'd0);
    check("t5_rst_mem_wdata", {16'd0, b_mem_wdata}, 32'd0);
    check("t5_rst_mem_we", {31'd0, b_mem_we}, 32'd0);
    check("t5_rst_rvalid", {31'd0, b_cpu_rvalid}, 32'd0);
    @(negedge clk);
    b_rst = 1'b1;
    n_rv = 0;
    repeat (6) begin
      @(negedge clk);
      if (b_cpu_rvalid) n_rv++;
    end
    check("t5_no_rvalid", n_rv, 32'd0);
    b_cpu_req = 1'b1; b_cpu_we = 1'b0; b_cpu_addr = 16'h0007;
    b_q.push_back(16'h1357);
    wait_gnt_b();
    check("t5_mem_addr", {16'd0, b_mem_addr}, 32'h0007);
    b_cpu_req = 1'b0;
    lat = 0; got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (b_cpu_rvalid) begin got = 1; break; end
    end
    check("t5_rvalid_seen", {31'd0, got}, 32'd1);
    check("t5_read_latency", lat, 32'd4);

    repeat (4) @(negedge clk);
    check("cpu_q_drained", cpu_q.size(), 32'd0);
    check("dbg_q_drained", dbg_q.size(), 32'd0);
    check("b_q_drained", b_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
